// File: rtl/alu_seq.sv
// alu_seq: registered ALU behind a start/busy/done handshake.
// Single-cycle ops: shifts, add/sub, logic. Iterative ops: unsigned multiply
// (shift-add) and, when ALU_SEQ_DIV_EN is defined, unsigned restoring divide,
// each taking WIDTH iterations. Without ALU_SEQ_DIV_EN opcode 1000 is illegal.
//
// Handshake: a request is accepted at a rising edge where start=1, busy=0 and
// rst=0; opcode and operands are captured at that edge. done is a one-cycle
// pulse in the cycle results/flags are written; results and flags then hold
// until the next completion. start is ignored at every edge where busy=1.
module alu_seq #(
    parameter int WIDTH = 16,
    localparam int SA_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_opsel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_result_l,
    output logic [WIDTH-1:0] alu_result_h,
    output logic             cf_flag,
    output logic             ovf_flag,
    output logic             zero_flag_l,
    output logic             zero_flag_h,
    output logic             dz_flag,
    output logic             err_flag,
    output logic             dbg_state     // FSM state: 0 = IDLE, 1 = ITER
);

    localparam logic [3:0] OP_SLL  = 4'b0000;
    localparam logic [3:0] OP_SRL  = 4'b0001;
    localparam logic [3:0] OP_SRA  = 4'b0010;
    localparam logic [3:0] OP_ROR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_MULU = 4'b0110;
    localparam logic [3:0] OP_DIVU = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1100;
    localparam logic [3:0] OP_OR   = 4'b1101;
    localparam logic [3:0] OP_XOR  = 4'b1110;
    localparam logic [3:0] OP_NOT  = 4'b1111;

    typedef enum logic {S_IDLE = 1'b0, S_ITER = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              accept, iter_last;

    // Iteration datapath: work_hi/work_lo hold the running {acc, multiplier}
    // for MULU or {remainder, dividend/quotient} for DIVU.
    logic [SA_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic [WIDTH-1:0]  work_hi_q, work_hi_d;
    logic [WIDTH-1:0]  work_lo_q, work_lo_d;
    logic [WIDTH-1:0]  step_hi, step_lo;

    // Output registers.
    logic [WIDTH-1:0]  res_l_q, res_l_d, res_h_q, res_h_d;
    logic              cf_q, cf_d, ovf_q, ovf_d, zl_q, zl_d, zh_q, zh_d;
    logic              dz_q, dz_d, err_q, err_d, done_q, done_d;

    // Single-cycle result of the op presented on the inputs.
    logic [WIDTH-1:0]  sc_l, sc_h;
    logic              sc_cf, sc_ovf, sc_dz, sc_err;
    logic              launch_mul, launch_div;

    logic [SA_W-1:0]   sa;
    logic [SA_W:0]     ror_back;
    logic [WIDTH:0]    add_full, sub_full;

    assign sa       = op_a[SA_W-1:0];
    assign ror_back = (SA_W+1)'(WIDTH) - {1'b0, sa};
    assign add_full = {1'b0, op_a} + {1'b0, op_b};
    assign sub_full = {1'b0, op_a} - {1'b0, op_b};

    // Decode and evaluate the single-cycle ops; flag which ops must iterate.
    always_comb begin
        sc_l       = '0;
        sc_h       = '0;
        sc_cf      = 1'b0;
        sc_ovf     = 1'b0;
        sc_dz      = 1'b0;
        sc_err     = 1'b0;
        launch_mul = 1'b0;
        launch_div = 1'b0;
        case (alu_opsel)
            OP_SLL:  sc_l = op_b << sa;
            OP_SRL:  sc_l = op_b >> sa;
            OP_SRA:  sc_l = $signed(op_b) >>> sa;
            OP_ROR:  sc_l = (op_b >> sa) | (op_b << ror_back);
            OP_ADD: begin
                sc_l   = add_full[WIDTH-1:0];
                sc_cf  = add_full[WIDTH];
                sc_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_full[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_l   = sub_full[WIDTH-1:0];
                sc_cf  = sub_full[WIDTH];
                sc_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_full[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_MULU: launch_mul = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU: begin
                // Divide by zero finishes immediately with a fixed pattern.
                if (op_b == '0) begin
                    sc_l  = '1;
                    sc_h  = op_a;
                    sc_dz = 1'b1;
                end else begin
                    launch_div = 1'b1;
                end
            end
`endif
            OP_AND:  sc_l = op_a & op_b;
            OP_OR:   sc_l = op_a | op_b;
            OP_XOR:  sc_l = op_a ^ op_b;
            OP_NOT:  sc_l = ~op_a;
            default: sc_err = 1'b1;
        endcase
    end

    // Multiply step: add multiplicand when the current multiplier bit is 1,
    // then shift {carry, acc, multiplier} right by one.
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  mul_hi, mul_lo;
    assign mul_sum = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], work_lo_q[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    logic              op_div_q, op_div_d;
    logic [WIDTH:0]    div_shift, div_trial;
    logic [WIDTH-1:0]  div_hi, div_lo;
    // Restoring divide step: shift next dividend bit into the remainder and
    // keep the trial subtraction only if it did not borrow.
    assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};
    assign div_hi    = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign div_lo    = {work_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
`endif

    // Select the iteration step for the running op.
    always_comb begin
        step_hi = mul_hi;
        step_lo = mul_lo;
`ifdef ALU_SEQ_DIV_EN
        if (op_div_q) begin
            step_hi = div_hi;
            step_lo = div_lo;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: iterate for MULU/DIVU, return when the count reaches 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && (launch_mul || launch_div)) state_d = S_ITER;
            S_ITER:  if (cnt_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy while iterating; requests only taken in IDLE.
    always_comb begin
        busy      = (state_q == S_ITER);
        iter_last = (state_q == S_ITER) && (cnt_q == '0);
        accept    = start && (state_q == S_IDLE);
        dbg_state = (state_q == S_ITER);
    end

    // Datapath next state: launch, iterate, or write a completion.
    always_comb begin
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
`ifdef ALU_SEQ_DIV_EN
        op_div_d  = op_div_q;
`endif
        res_l_d   = res_l_q;
        res_h_d   = res_h_q;
        cf_d      = cf_q;
        ovf_d     = ovf_q;
        zl_d      = zl_q;
        zh_d      = zh_q;
        dz_d      = dz_q;
        err_d     = err_q;
        done_d    = 1'b0;
        if (accept) begin
            if (launch_mul || launch_div) begin
                cnt_d     = SA_W'(WIDTH - 1);
                opnd_d    = op_b;
                work_hi_d = '0;
                work_lo_d = op_a;
`ifdef ALU_SEQ_DIV_EN
                op_div_d  = launch_div;
`endif
            end else begin
                res_l_d = sc_l;
                res_h_d = sc_h;
                cf_d    = sc_cf;
                ovf_d   = sc_ovf;
                zl_d    = ~|sc_l;
                zh_d    = ~|sc_h;
                dz_d    = sc_dz;
                err_d   = sc_err;
                done_d  = 1'b1;
            end
        end else if (state_q == S_ITER) begin
            cnt_d     = cnt_q - 1'b1;
            work_hi_d = step_hi;
            work_lo_d = step_lo;
            if (iter_last) begin
                res_l_d = step_lo;
                res_h_d = step_hi;
                cf_d    = 1'b0;
                ovf_d   = 1'b0;
                zl_d    = ~|step_lo;
                zh_d    = ~|step_hi;
                dz_d    = 1'b0;
                err_d   = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    // Datapath and output registers; reset clears every output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            opnd_q    <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
`ifdef ALU_SEQ_DIV_EN
            op_div_q  <= 1'b0;
`endif
            res_l_q   <= '0;
            res_h_q   <= '0;
            cf_q      <= 1'b0;
            ovf_q     <= 1'b0;
            zl_q      <= 1'b0;
            zh_q      <= 1'b0;
            dz_q      <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
`ifdef ALU_SEQ_DIV_EN
            op_div_q  <= op_div_d;
`endif
            res_l_q   <= res_l_d;
            res_h_q   <= res_h_d;
            cf_q      <= cf_d;
            ovf_q     <= ovf_d;
            zl_q      <= zl_d;
            zh_q      <= zh_d;
            dz_q      <= dz_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign done         = done_q;
    assign alu_result_l = res_l_q;
    assign alu_result_h = res_h_q;
    assign cf_flag      = cf_q;
    assign ovf_flag     = ovf_q;
    assign zero_flag_l  = zl_q;
    assign zero_flag_h  = zh_q;
    assign dz_flag      = dz_q;
    assign err_flag     = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq at WIDTH=8.
// An arithmetic model predicts every completion; a compare process checks
// each done pulse against the expected queue. Literal checks pin the model.
module tb_alu_seq;
    localparam int W        = 8;
    localparam int EW       = 2 * W + 6;
    localparam int MAX_WAIT = 40;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   alu_opsel;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, cf_flag, ovf_flag, zero_flag_l, zero_flag_h;
    logic         dz_flag, err_flag, dbg_state;
    logic [W-1:0] alu_result_l, alu_result_h;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_opsel(alu_opsel),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .alu_result_l(alu_result_l), .alu_result_h(alu_result_h),
        .cf_flag(cf_flag), .ovf_flag(ovf_flag), .zero_flag_l(zero_flag_l),
        .zero_flag_h(zero_flag_h), .dz_flag(dz_flag), .err_flag(err_flag),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_exp;
    logic [EW-1:0] act;
    int            total = 0, bad = 0;          // driver-side checks (+ folded at end)
    int            cmp_total = 0, cmp_bad = 0;  // compare-process checks

    assign act = {alu_result_l, alu_result_h, cf_flag, ovf_flag,
                  zero_flag_l, zero_flag_h, dz_flag, err_flag};

    // Arithmetic model: what the completion of (op, a, b) must show.
    function automatic logic [EW-1:0] model(input logic [3:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        int ua, ub, sa_, sb_, amt, r, lo, hi;
        bit cf, ovf, dz, err;
        ua  = int'(a);
        ub  = int'(b);
        sa_ = (ua >= 128) ? ua - 256 : ua;
        sb_ = (ub >= 128) ? ub - 256 : ub;
        amt = ua % W;
        lo = 0; hi = 0; cf = 0; ovf = 0; dz = 0; err = 0;
        case (op)
            4'd0: lo = (ub * (1 << amt)) % 256;
            4'd1: lo = ub / (1 << amt);
            4'd2: begin
                r = sb_;
                for (int i = 0; i < amt; i++) r = (r < 0 && (r % 2) != 0) ? (r - 1) / 2 : r / 2;
                lo = r & 255;
            end
            4'd3: begin
                lo = ub;
                for (int i = 0; i < amt; i++) lo = (lo / 2) + (lo % 2) * 128;
            end
            4'd4: begin
                r = ua + ub; lo = r % 256; cf = (r > 255);
                r = sa_ + sb_; ovf = (r > 127) || (r < -128);
            end
            4'd5: begin
                r = ua - ub; lo = (r + 256) % 256; cf = (ua < ub);
                r = sa_ - sb_; ovf = (r > 127) || (r < -128);
            end
            4'd6: begin
                r = ua * ub; lo = r % 256; hi = r / 256;
            end
`ifdef ALU_SEQ_DIV_EN
            4'd8: begin
                if (ub == 0) begin lo = 255; hi = ua; dz = 1; end
                else begin lo = ua / ub; hi = ua % ub; end
            end
`endif
            4'd12: lo = ua & ub;
            4'd13: lo = ua | ub;
            4'd14: lo = ua ^ ub;
            4'd15: lo = 255 - ua;
            default: err = 1;
        endcase
        return {W'(lo), W'(hi), cf, ovf, (lo == 0), (hi == 0), dz, err};
    endfunction

    // Negedge count from the accepting edge to the done cycle.
    function automatic int exp_cycles(input logic [3:0] op, input logic [W-1:0] b);
        if (op == 4'd6) return W + 1;
`ifdef ALU_SEQ_DIV_EN
        if (op == 4'd8 && b != '0) return W + 1;
`endif
        return 1;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            cmp_total++;
            if (exp_q.size() == 0) begin
                cmp_bad++;
                $display("FAIL unexpected_done got=%h required=no completion", act);
            end else begin
                last_exp = exp_q.pop_front();
                if (act !== last_exp) begin
                    cmp_bad++;
                    $display("FAIL result got=%h required=%h", act, last_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // noise: 0 none, 1 start pulse at cycle 3, 2 start held through completion.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int noise);
        int want, n;
        bit seen;
        want = exp_cycles(op, b);
        @(negedge clk);
        alu_opsel = op; op_a = a; op_b = b; start = 1'b1;
        exp_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        start     = (noise == 2);
        alu_opsel = 4'b0100;
        op_a      = ~a;
        op_b      = a ^ b;
        n = 0;
        seen = 0;
        while (!seen && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
            if (noise == 1) start = (n == 3);
            if (done) seen = 1;
            else chk("busy_during_op", {31'd0, busy}, {31'd0, want > 1});
        end
        start = 1'b0;
        chk("done_latency", n, want);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    logic [3:0]   v_op [20] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5, 4'd5, 4'd12, 4'd13,
                                4'd15, 4'd6, 4'd6, 4'd6, 4'd8, 4'd8, 4'd8, 4'd7, 4'd10, 4'd11};
    logic [W-1:0] v_a  [20] = '{8'h03, 8'h07, 8'h02, 8'h00, 8'h0B, 8'hFF, 8'h80, 8'h05, 8'hF0, 8'h0F,
                                8'hA5, 8'h0D, 8'h00, 8'h10, 8'hFF, 8'h03, 8'hFF, 8'h12, 8'h34, 8'h56};
    logic [W-1:0] v_b  [20] = '{8'h01, 8'h80, 8'h7F, 8'hA5, 8'h81, 8'h01, 8'h01, 8'h05, 8'h3C, 8'h30,
                                8'h00, 8'h0B, 8'h37, 8'h10, 8'h10, 8'h07, 8'h01, 8'h34, 8'h56, 8'h78};
    logic [3:0]   b_op [5]  = '{4'd4, 4'd14, 4'd0, 4'd5, 4'd15};
    logic [W-1:0] b_a  [5]  = '{8'h01, 8'hFF, 8'h01, 8'h10, 8'h00};
    logic [W-1:0] b_b  [5]  = '{8'h02, 8'h0F, 8'h01, 8'h20, 8'h00};

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; alu_opsel = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {9'd0, busy, done, dbg_state, act}, 32'd0);
        rst = 1'b0;

        // Directed vectors with hand-computed values.
        run_op(4'b0100, 8'h7F, 8'h01, 0);
        chk("add_l", alu_result_l, 8'h80);
        chk("add_ovf", ovf_flag, 1);
        chk("add_cf", cf_flag, 0);
        run_op(4'b0101, 8'h00, 8'h01, 0);
        chk("sub_l", alu_result_l, 8'hFF);
        chk("sub_cf", cf_flag, 1);
        chk("sub_ovf", ovf_flag, 0);
        run_op(4'b0110, 8'hFF, 8'hFF, 1);
        chk("mul_h", alu_result_h, 8'hFE);
        chk("mul_l", alu_result_l, 8'h01);
        run_op(4'b0110, 8'hFF, 8'hFF, 2);
        @(negedge clk);
        chk("no_restart_at_done", done, 0);
        chk("mul_hold", act, last_exp);
        run_op(4'b1000, 8'h64, 8'h07, 0);
`ifdef ALU_SEQ_DIV_EN
        chk("div_l", alu_result_l, 8'h0E);
        chk("div_h", alu_result_h, 8'h02);
        chk("div_dz", dz_flag, 0);
        run_op(4'b1000, 8'h64, 8'h00, 0);
        chk("divz_l", alu_result_l, 8'hFF);
        chk("divz_h", alu_result_h, 8'h64);
        chk("divz_dz", dz_flag, 1);
`else
        chk("nodiv_err", err_flag, 1);
        chk("nodiv_l", alu_result_l, 8'h00);
        chk("nodiv_h", alu_result_h, 8'h00);
`endif
        run_op(4'b0010, 8'h03, 8'h80, 0);
        chk("sra_l", alu_result_l, 8'hF0);
        run_op(4'b0011, 8'h01, 8'h01, 0);
        chk("ror_l", alu_result_l, 8'h80);
        run_op(4'b1110, 8'h5A, 8'h5A, 0);
        chk("xor_l", alu_result_l, 8'h00);
        chk("xor_zl", zero_flag_l, 1);
        run_op(4'b1001, 8'h12, 8'h34, 0);
        chk("illegal_err", err_flag, 1);
        chk("illegal_res", {alu_result_h, alu_result_l}, 16'h0000);
        chk("illegal_zero", {zero_flag_h, zero_flag_l}, 2'b11);

        // Broader vector table checked through the model.
        for (int i = 0; i < 20; i++) run_op(v_op[i], v_a[i], v_b[i], 0);

        // Back-to-back single-cycle ops: done stays high.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) chk("burst_done", done, 1);
            alu_opsel = b_op[i]; op_a = b_a[i]; op_b = b_b[i]; start = 1'b1;
            exp_q.push_back(model(b_op[i], b_a[i], b_b[i]));
        end
        @(negedge clk);
        chk("burst_done_last", done, 1);
        start = 1'b0;
        @(negedge clk);
        chk("burst_end", done, 0);
        chk("burst_hold", act, last_exp);

        // Reset in cycle 4 of a multiply aborts it without done.
        @(negedge clk);
        alu_opsel = 4'b0110; op_a = 8'hFF; op_b = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_abort_outs", {9'd0, busy, done, dbg_state, act}, 32'd0);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end

        // start coincident with reset is lost.
        @(negedge clk);
        rst = 1'b1; alu_opsel = 4'b0100; op_a = 8'h01; op_b = 8'h01; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_outs", {9'd0, busy, done, dbg_state, act}, 32'd0);
        @(negedge clk);
        chk("rst_start_lost", done, 0);

        run_op(4'b0100, 8'h11, 8'h22, 0);
        chk("post_rst_add", alu_result_l, 8'h33);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        total = total + cmp_total;
        bad   = bad + cmp_bad;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
